id_ex_stage: RTL and testbench

ID/EX pipeline stage that sits directly downstream of the register file read ports. It captures decoded fields and `rs1_data`/`rs2_data` and resolves RAW hazards by forwarding from EX, MEM and WB. It detects load-use hazards and inserts one bubble, and presents a registered valid/ready handshake to the EX stage. A saturating counter of load-use stall cycles is exported for performance monitoring.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/id_ex_stage_if.sv | 67 ++++++
 rtl/id_ex_stage_fwd.sv | 45 ++++
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, register index width and
// operand forwarding source encoding.
package pipe_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_ZERO
    } fwd_sel_e;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_e;
endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode/forwarding sources and the ID/EX stage.
// slave is the stage itself; master is whatever drives it.
interface id_ex_stage_if;
    import pipe_pkg::*;

    logic              id_valid_i;
    logic              id_ready_o;
    logic [XLEN-1:0]   id_pc_i;
    logic [XLEN-1:0]   id_instr_i;
    logic [REG_AW-1:0] rs1_addr_i;
    logic [REG_AW-1:0] rs2_addr_i;
    logic [REG_AW-1:0] rd_addr_i;
    logic              rs1_used_i;
    logic              rs2_used_i;
    logic              rd_wren_i;
    logic              is_load_i;
    logic [XLEN-1:0]   rs1_data_i;
    logic [XLEN-1:0]   rs2_data_i;

    logic              ex_fwd_wren_i;
    logic [REG_AW-1:0] ex_fwd_addr_i;
    logic [XLEN-1:0]   ex_fwd_data_i;
    logic              mem_fwd_wren_i;
    logic [REG_AW-1:0] mem_fwd_addr_i;
    logic [XLEN-1:0]   mem_fwd_data_i;
    logic              wb_wren_i;
    logic [REG_AW-1:0] wb_addr_i;
    logic [XLEN-1:0]   wb_data_i;

    logic              flush_i;
    logic              ex_valid_o;
    logic              ex_ready_i;
    logic [XLEN-1:0]   ex_pc_o;
    logic [XLEN-1:0]   ex_instr_o;
    logic [XLEN-1:0]   ex_rs1_data_o;
    logic [XLEN-1:0]   ex_rs2_data_o;
    logic [REG_AW-1:0] ex_rd_addr_o;
    logic              ex_rd_wren_o;
    logic              ex_is_load_o;
    logic [31:0]       stall_cnt_o;

    modport slave (
        input  id_valid_i, id_pc_i, id_instr_i,
        input  rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_used_i, rs2_used_i,
        input  rd_wren_i, is_load_i, rs1_data_i, rs2_data_i,
        input  ex_fwd_wren_i, ex_fwd_addr_i, ex_fwd_data_i,
        input  mem_fwd_wren_i, mem_fwd_addr_i, mem_fwd_data_i,
        input  wb_wren_i, wb_addr_i, wb_data_i,
        input  flush_i, ex_ready_i,
        output id_ready_o, ex_valid_o, ex_pc_o, ex_instr_o,
        output ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_rd_wren_o,
        output ex_is_load_o, stall_cnt_o
    );

    modport master (
        output id_valid_i, id_pc_i, id_instr_i,
        output rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_used_i, rs2_used_i,
        output rd_wren_i, is_load_i, rs1_data_i, rs2_data_i,
        output ex_fwd_wren_i, ex_fwd_addr_i, ex_fwd_data_i,
        output mem_fwd_wren_i, mem_fwd_addr_i, mem_fwd_data_i,
        output wb_wren_i, wb_addr_i, wb_data_i,
        output flush_i, ex_ready_i,
        input  id_ready_o, ex_valid_o, ex_pc_o, ex_instr_o,
        input  ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o, ex_rd_wren_o,
        input  ex_is_load_o, stall_cnt_o
    );
endinterface

// File: rtl/id_ex_stage_fwd.sv
// Per-source operand bypass: x0, then EX, MEM, WB, then register file.
module operand_fwd
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] src_addr,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              ex_wren,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_addr,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              mem_wren,
    input  logic [REG_AW-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_wren,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output fwd_sel_e          sel,
    output logic [XLEN-1:0]   data
);

    always_comb begin
        sel = FWD_RF;
        if (src_addr == '0)
            sel = FWD_ZERO;
        else if (ex_wren && !ex_is_load && ex_addr == src_addr)
            sel = FWD_EX;
        else if (mem_wren && mem_addr == src_addr)
            sel = FWD_MEM;
        // register file writes land too late for a same-cycle read
        else if (wb_wren && wb_addr == src_addr)
            sel = FWD_WB;
    end

    always_comb begin
        data = rf_data;
        case (sel)
            FWD_ZERO: data = '0;
            FWD_EX:   data = ex_data;
            FWD_MEM:  data = mem_data;
            FWD_WB:   data = wb_data;
            default:  data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion
// and a saturating stall-cycle counter.
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    id_ex_stage_if.slave bus
);

    // state    | meaning
    // ST_EMPTY | output register holds no instruction (ex_valid_o = 0)
    // ST_FULL  | output register holds a valid instruction for EX

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, instr_q, rs1_q, rs2_q;
    logic [REG_AW-1:0] rd_q;
    logic              wren_q, load_q;
    logic [31:0]       cnt_q;

    logic              full, advance, src_hit, hazard, accept;
    fwd_sel_e          rs1_sel, rs2_sel;
    logic [XLEN-1:0]   rs1_fwd, rs2_fwd;

    assign full    = (state_q == ST_FULL);
    assign advance = !full || bus.ex_ready_i;
    assign src_hit = (bus.rs1_used_i && bus.rs1_addr_i == rd_q) ||
                     (bus.rs2_used_i && bus.rs2_addr_i == rd_q);
    assign hazard  = bus.id_valid_i && full && load_q && wren_q &&
                     (rd_q != '0) && src_hit;
    assign accept  = bus.id_valid_i && bus.id_ready_o && !bus.flush_i;

    operand_fwd u_fwd_rs1 (
        .src_addr   (bus.rs1_addr_i),
        .rf_data    (bus.rs1_data_i),
        .ex_wren    (bus.ex_fwd_wren_i),
        .ex_is_load (load_q),
        .ex_addr    (bus.ex_fwd_addr_i),
        .ex_data    (bus.ex_fwd_data_i),
        .mem_wren   (bus.mem_fwd_wren_i),
        .mem_addr   (bus.mem_fwd_addr_i),
        .mem_data   (bus.mem_fwd_data_i),
        .wb_wren    (bus.wb_wren_i),
        .wb_addr    (bus.wb_addr_i),
        .wb_data    (bus.wb_data_i),
        .sel        (rs1_sel),
        .data       (rs1_fwd)
    );

    operand_fwd u_fwd_rs2 (
        .src_addr   (bus.rs2_addr_i),
        .rf_data    (bus.rs2_data_i),
        .ex_wren    (bus.ex_fwd_wren_i),
        .ex_is_load (load_q),
        .ex_addr    (bus.ex_fwd_addr_i),
        .ex_data    (bus.ex_fwd_data_i),
        .mem_wren   (bus.mem_fwd_wren_i),
        .mem_addr   (bus.mem_fwd_addr_i),
        .mem_data   (bus.mem_fwd_data_i),
        .wb_wren    (bus.wb_wren_i),
        .wb_addr    (bus.wb_addr_i),
        .wb_data    (bus.wb_data_i),
        .sel        (rs2_sel),
        .data       (rs2_fwd)
    );

    // x0 reads must never pick up a forwarded value
    always_comb begin
        assert (rs1_sel != FWD_ZERO || rs1_fwd == '0);
        assert (rs2_sel != FWD_ZERO || rs2_fwd == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i)
            state_d = ST_EMPTY;
        else if (accept)
            state_d = ST_FULL;
        else if (advance)
            state_d = ST_EMPTY;
    end

    always_comb begin
        bus.ex_valid_o = (state_q == ST_FULL);
        bus.id_ready_o = bus.flush_i || (advance && !hazard);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            instr_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            wren_q  <= 1'b0;
            load_q  <= 1'b0;
        end else if (accept) begin
            pc_q    <= bus.id_pc_i;
            instr_q <= bus.id_instr_i;
            rs1_q   <= rs1_fwd;
            rs2_q   <= rs2_fwd;
            rd_q    <= bus.rd_addr_i;
            wren_q  <= bus.rd_wren_i;
            load_q  <= bus.is_load_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (hazard && !bus.flush_i && cnt_q != 32'hFFFF_FFFF)
            cnt_q <= cnt_q + 32'd1;
    end

    assign bus.ex_pc_o       = pc_q;
    assign bus.ex_instr_o    = instr_q;
    assign bus.ex_rs1_data_o = rs1_q;
    assign bus.ex_rs2_data_o = rs2_q;
    assign bus.ex_rd_addr_o  = rd_q;
    assign bus.ex_rd_wren_o  = wren_q;
    assign bus.ex_is_load_o  = load_q;
    assign bus.stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: forwarding-priority table, directed pipeline
// scenarios and randomized traffic against a reference pipeline model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    logic last_ready;

    // reference state of the output register
    logic        m_valid = 0, m_wren = 0, m_load = 0;
    logic [31:0] m_pc = 0, m_instr = 0, m_rs1 = 0, m_rs2 = 0, m_cnt = 0;
    logic [4:0]  m_rd = 0;

    typedef struct packed {
        logic [4:0]  rs1;
        logic        ex_w;
        logic [4:0]  ex_a;
        logic        mem_w;
        logic [4:0]  mem_a;
        logic        wb_w;
        logic [4:0]  wb_a;
        logic [31:0] exp;
    } fwd_vec_t;
    fwd_vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_opnd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'd0;
        if (bus.ex_fwd_wren_i && bus.ex_fwd_addr_i == a && !m_load) return bus.ex_fwd_data_i;
        if (bus.mem_fwd_wren_i && bus.mem_fwd_addr_i == a) return bus.mem_fwd_data_i;
        if (bus.wb_wren_i && bus.wb_addr_i == a) return bus.wb_data_i;
        return rf;
    endfunction

    task automatic set_idle();
        bus.id_valid_i = 0; bus.id_pc_i = 0; bus.id_instr_i = 0;
        bus.rs1_addr_i = 0; bus.rs2_addr_i = 0; bus.rd_addr_i = 0;
        bus.rs1_used_i = 0; bus.rs2_used_i = 0; bus.rd_wren_i = 0; bus.is_load_i = 0;
        bus.rs1_data_i = 0; bus.rs2_data_i = 0;
        bus.ex_fwd_wren_i = 0; bus.ex_fwd_addr_i = 0; bus.ex_fwd_data_i = 0;
        bus.mem_fwd_wren_i = 0; bus.mem_fwd_addr_i = 0; bus.mem_fwd_data_i = 0;
        bus.wb_wren_i = 0; bus.wb_addr_i = 0; bus.wb_data_i = 0;
        bus.flush_i = 0; bus.ex_ready_i = 1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] rd, input logic wr,
                         input logic ld, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2);
        bus.id_valid_i = 1; bus.id_pc_i = pc; bus.id_instr_i = ~pc;
        bus.rd_addr_i = rd; bus.rd_wren_i = wr; bus.is_load_i = ld;
        bus.rs1_addr_i = r1; bus.rs1_used_i = u1; bus.rs2_addr_i = r2; bus.rs2_used_i = u2;
    endtask

    // one clock: check id_ready against the model, advance the model, check outputs
    task automatic cycle();
        logic adv, haz, exp_rdy;
        logic [31:0] o1, o2;
        #1;
        adv = !m_valid || bus.ex_ready_i;
        haz = bus.id_valid_i && m_valid && m_load && m_wren && m_rd != 0 &&
              ((bus.rs1_used_i && bus.rs1_addr_i == m_rd) ||
               (bus.rs2_used_i && bus.rs2_addr_i == m_rd));
        exp_rdy = bus.flush_i || (adv && !haz);
        last_ready = bus.id_ready_o;
        chk("id_ready", 32'(bus.id_ready_o), 32'(exp_rdy));
        o1 = m_opnd(bus.rs1_addr_i, bus.rs1_data_i);
        o2 = m_opnd(bus.rs2_addr_i, bus.rs2_data_i);
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_pc = 0; m_instr = 0; m_rs1 = 0; m_rs2 = 0;
            m_rd = 0; m_wren = 0; m_load = 0; m_cnt = 0;
        end else begin
            if (haz && !bus.flush_i && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (bus.flush_i) m_valid = 0;
            else if (bus.id_valid_i && exp_rdy) begin
                m_valid = 1; m_pc = bus.id_pc_i; m_instr = bus.id_instr_i;
                m_rs1 = o1; m_rs2 = o2; m_rd = bus.rd_addr_i;
                m_wren = bus.rd_wren_i; m_load = bus.is_load_i;
            end else if (adv) m_valid = 0;
        end
        chk("ex_valid", 32'(bus.ex_valid_o), 32'(m_valid));
        chk("stall_cnt", bus.stall_cnt_o, m_cnt);
        if (m_valid) begin
            chk("ex_pc", bus.ex_pc_o, m_pc);
            chk("ex_instr", bus.ex_instr_o, m_instr);
            chk("ex_rs1", bus.ex_rs1_data_o, m_rs1);
            chk("ex_rs2", bus.ex_rs2_data_o, m_rs2);
            chk("ex_rd", 32'(bus.ex_rd_addr_o), 32'(m_rd));
            chk("ex_wren", 32'(bus.ex_rd_wren_o), 32'(m_wren));
            chk("ex_load", 32'(bus.ex_is_load_o), 32'(m_load));
        end
    endtask

    task automatic do_reset();
        rst = 1; set_idle();
        cycle();
        rst = 0;
    endtask

    initial begin
        set_idle();
        rst = 1;
        @(posedge clk); #1;
        cycle();
        rst = 0;

        // forwarding priority: ex=E, mem=A, wb=B, rf=F
        tbl[0] = '{5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 32'hE};
        tbl[1] = '{5'd3, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 32'hA};
        tbl[2] = '{5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd3, 32'hA};
        tbl[3] = '{5'd3, 1'b0, 5'd3, 1'b0, 5'd3, 1'b1, 5'd3, 32'hB};
        tbl[4] = '{5'd3, 1'b0, 5'd3, 1'b0, 5'd3, 1'b0, 5'd3, 32'hF};
        tbl[5] = '{5'd3, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 5'd4, 32'hF};
        tbl[6] = '{5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0};
        tbl[7] = '{5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'hE};
        for (int i = 0; i < 8; i++) begin
            set_idle();
            offer(32'h40 + 32'(i), 5'd9, 1'b1, 1'b0, tbl[i].rs1, 1'b1, 5'd0, 1'b0);
            bus.rs1_data_i = 32'hF;
            bus.ex_fwd_wren_i = tbl[i].ex_w;   bus.ex_fwd_addr_i = tbl[i].ex_a;   bus.ex_fwd_data_i = 32'hE;
            bus.mem_fwd_wren_i = tbl[i].mem_w; bus.mem_fwd_addr_i = tbl[i].mem_a; bus.mem_fwd_data_i = 32'hA;
            bus.wb_wren_i = tbl[i].wb_w;       bus.wb_addr_i = tbl[i].wb_a;       bus.wb_data_i = 32'hB;
            cycle();
            chk("tbl_rs1", bus.ex_rs1_data_o, tbl[i].exp);
        end

        // back-to-back ALU: addi x5,x0,7 then add x6,x5,x5
        do_reset();
        offer(32'h100, 5'd5, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        cycle();
        offer(32'h104, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1);
        bus.ex_fwd_wren_i = 1; bus.ex_fwd_addr_i = 5; bus.ex_fwd_data_i = 7;
        cycle();
        chk("b2b_ready", 32'(last_ready), 32'd1);
        chk("b2b_rs1", bus.ex_rs1_data_o, 32'd7);
        chk("b2b_rs2", bus.ex_rs2_data_o, 32'd7);
        chk("b2b_valid", 32'(bus.ex_valid_o), 32'd1);

        // load-use: lw x7 then add x8,x7,x1
        do_reset();
        offer(32'h200, 5'd7, 1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        cycle();
        set_idle();
        offer(32'h204, 5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd1, 1'b1);
        bus.rs2_data_i = 32'h11;
        cycle();
        chk("lu_ready", 32'(last_ready), 32'd0);
        chk("lu_bubble", 32'(bus.ex_valid_o), 32'd0);
        chk("lu_cnt", bus.stall_cnt_o, 32'd1);
        bus.mem_fwd_wren_i = 1; bus.mem_fwd_addr_i = 7; bus.mem_fwd_data_i = 32'h1234;
        cycle();
        chk("lu_ready2", 32'(last_ready), 32'd1);
        chk("lu_rs1", bus.ex_rs1_data_o, 32'h1234);
        chk("lu_rs2", bus.ex_rs2_data_o, 32'h11);
        chk("lu_cnt2", bus.stall_cnt_o, 32'd1);

        // WB bypass with stale register file data
        set_idle();
        offer(32'h300, 5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        bus.wb_wren_i = 1; bus.wb_addr_i = 3; bus.wb_data_i = 32'hDEADBEEF;
        cycle();
        chk("wb_rs1", bus.ex_rs1_data_o, 32'hDEADBEEF);

        // x0: load to x0 held, EX forwarding x0=0x55
        set_idle();
        offer(32'h400, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        cycle();
        offer(32'h404, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        bus.rs1_data_i = 32'h99; bus.rs2_data_i = 32'h99;
        bus.ex_fwd_wren_i = 1; bus.ex_fwd_addr_i = 0; bus.ex_fwd_data_i = 32'h55;
        cycle();
        chk("x0_ready", 32'(last_ready), 32'd1);
        chk("x0_rs1", bus.ex_rs1_data_o, 32'd0);
        chk("x0_rs2", bus.ex_rs2_data_o, 32'd0);

        // backpressure for 3 cycles, then flush
        set_idle();
        offer(32'h500, 5'd3, 1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);
        bus.rs1_data_i = 32'hAAAA;
        cycle();
        for (int i = 0; i < 3; i++) begin
            offer(32'h600 + 32'(i), 5'd4, 1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);
            bus.ex_ready_i = 0;
            bus.rs1_data_i = $urandom;
            bus.mem_fwd_wren_i = 1; bus.mem_fwd_addr_i = 1; bus.mem_fwd_data_i = $urandom;
            cycle();
            chk("bp_ready", 32'(last_ready), 32'd0);
            chk("bp_pc", bus.ex_pc_o, 32'h500);
            chk("bp_rs1", bus.ex_rs1_data_o, 32'hAAAA);
        end
        bus.flush_i = 1;
        cycle();
        chk("fl_ready", 32'(last_ready), 32'd1);
        chk("fl_valid", 32'(bus.ex_valid_o), 32'd0);

        // reset while FULL with stall count 5
        do_reset();
        offer(32'h700, 5'd7, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        cycle();
        offer(32'h704, 5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        bus.ex_ready_i = 0;
        for (int i = 0; i < 5; i++) cycle();
        chk("rst_pre_cnt", bus.stall_cnt_o, 32'd5);
        chk("rst_pre_valid", 32'(bus.ex_valid_o), 32'd1);
        rst = 1;
        cycle();
        rst = 0;
        chk("rst_valid", 32'(bus.ex_valid_o), 32'd0);
        chk("rst_cnt", bus.stall_cnt_o, 32'd0);
        chk("rst_pc", bus.ex_pc_o, 32'd0);
        chk("rst_rd", 32'(bus.ex_rd_addr_o), 32'd0);
        chk("rst_ctl", 32'({bus.ex_rd_wren_o, bus.ex_is_load_o}), 32'd0);
        set_idle();
        cycle();
        chk("rst_lost", 32'(bus.ex_valid_o), 32'd0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.id_valid_i = ($urandom_range(0, 3) != 0);
            bus.id_pc_i = $urandom; bus.id_instr_i = $urandom;
            bus.rs1_addr_i = 5'($urandom_range(0, 3));
            bus.rs2_addr_i = 5'($urandom_range(0, 3));
            bus.rd_addr_i  = 5'($urandom_range(0, 3));
            bus.rs1_used_i = 1'($urandom_range(0, 1));
            bus.rs2_used_i = 1'($urandom_range(0, 1));
            bus.rd_wren_i  = ($urandom_range(0, 3) != 0);
            bus.is_load_i  = ($urandom_range(0, 2) == 0);
            bus.rs1_data_i = $urandom; bus.rs2_data_i = $urandom;
            bus.ex_fwd_wren_i = 1'($urandom_range(0, 1));
            bus.ex_fwd_addr_i = 5'($urandom_range(0, 3)); bus.ex_fwd_data_i = $urandom;
            bus.mem_fwd_wren_i = 1'($urandom_range(0, 1));
            bus.mem_fwd_addr_i = 5'($urandom_range(0, 3)); bus.mem_fwd_data_i = $urandom;
            bus.wb_wren_i = 1'($urandom_range(0, 1));
            bus.wb_addr_i = 5'($urandom_range(0, 3)); bus.wb_data_i = $urandom;
            bus.flush_i = ($urandom_range(0, 19) == 0);
            bus.ex_ready_i = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
